uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among NREQ byte sources. Round-robin grant, latches granted byte,

---
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Optional WAIT_BUSY timeout with sticky tx_err is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arb_en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [IDW-1:0]    grant_id,
  output logic              arb_busy,
  output logic [7:0]        Tx_data,
  output logic              Tx_wr,
  output logic              Tx_en,
  input  logic              Tx_busy,
  output logic              tx_err
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] sel;
  logic           grant_ok;
  logic           to_hit;

  // First pending request at or after p, wrapping NREQ-1 -> 0.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
    logic [IDW-1:0]  pick;
    logic [NREQ-1:0] sh;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(p) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sh = r >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [7:0] byte_of(input logic [8*NREQ-1:0] d, input logic [IDW-1:0] i);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < NREQ; k++)
      if (i == IDW'(k)) b = d[8*k +: 8];
    return b;
  endfunction

  assign sel      = rr_pick(req, ptr);
  assign grant_ok = Tx_en && !Tx_busy && (|req);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT - 1));

  // Counter sits at zero outside WAIT_BUSY, so it is clear on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
      tx_err <= 1'b0;
    end else if (state == WAIT_BUSY && !Tx_busy) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_hit) tx_err <= 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit = 1'b0;
  assign tx_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ack      <= '0;
      grant_id <= '0;
      arb_busy <= 1'b0;
      Tx_data  <= 8'h00;
      Tx_wr    <= 1'b0;
      Tx_en    <= 1'b0;
      ptr      <= '0;
    end else begin
      Tx_en <= arb_en;
      ack   <= '0;
      Tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            Tx_data  <= byte_of(req_data, sel);
            grant_id <= sel;
            ack      <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            ptr      <= next_idx(sel);
            arb_busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          Tx_wr <= 1'b1;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (Tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_hit) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (!Tx_busy) begin
            state    <= IDLE;
            arb_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected grants are queued as requests are raised
// and checked against ack/Tx_wr/Tx_data/grant_id as frames are issued.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arb_en = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = 32'h13121110;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic [7:0]  Tx_data;
  logic        Tx_wr;
  logic        Tx_en;
  logic        Tx_busy = 1'b0;
  logic        tx_err;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   pend[4] = '{0, 0, 0, 0};
  bit   model_en = 1'b1;
  bit   prev_ack = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_tx_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en), .req(req), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .arb_busy(arb_busy), .Tx_data(Tx_data),
    .Tx_wr(Tx_wr), .Tx_en(Tx_en), .Tx_busy(Tx_busy), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor and requester model, both on the falling edge.
  initial begin
    exp_t        e;
    logic [31:0] one;
    one = 32'd1;
    forever begin
      @(negedge clk);
      if (ack != 4'b0000) begin
        if (q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
        else check("ack_onehot", 32'(ack), one << q[0].id);
      end
      if (Tx_wr) begin
        check("wr_after_ack", 32'(prev_ack), 32'd1);
        if (q.size() == 0) begin
          check("wr_unexpected", 32'(Tx_wr), 32'd0);
        end else begin
          e = q.pop_front();
          check("tx_data", 32'(Tx_data), 32'(e.data));
          check("grant_id", 32'(grant_id), 32'(e.id));
        end
      end
      prev_ack = (ack != 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (ack[i] && pend[i] > 0) pend[i]--;
        req[i] = (pend[i] != 0);
      end
    end
  end

  // Transmitter model: busy rises one cycle after Tx_wr and stays up for 10 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (Tx_wr && model_en) begin
        @(posedge clk);
        #1 Tx_busy = 1'b1;
        repeat (10) @(posedge clk);
        #1 Tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_ack(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) seen = 1'b1;
    end
    check("wait_ack", 32'(seen), 32'd1);
  endtask

  task automatic wait_wr(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (Tx_wr) seen = 1'b1;
    end
    check("wait_wr", 32'(seen), 32'd1);
  endtask

  task automatic wait_busy(input logic val, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (Tx_busy === val) seen = 1'b1;
    end
    check("wait_busy", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && pend[0] == 0 && pend[1] == 0 && pend[2] == 0 && pend[3] == 0
          && !arb_busy && !Tx_busy) done = 1'b1;
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_arb_busy"}, 32'(arb_busy), 32'd0);
    check({tag, "_tx_data"}, 32'(Tx_data), 32'd0);
    check({tag, "_tx_wr"}, 32'(Tx_wr), 32'd0);
    check({tag, "_tx_en"}, 32'(Tx_en), 32'd0);
    check({tag, "_tx_err"}, 32'(tx_err), 32'd0);
  endtask

  initial begin
    // Power-on reset values
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("tx_en_on", 32'(Tx_en), 32'd1);

    // Single requester 0 with byte A5
    req_data = 32'h131211A5;
    push(2'd0, 8'hA5);
    pend[0] = 1;
    wait_ack(20);
    check("t2_ack", 32'(ack), 32'h1);
    check("t2_grant", 32'(grant_id), 32'd0);
    check("t2_busy", 32'(arb_busy), 32'd1);
    check("t2_wr_lat", 32'(Tx_wr), 32'd0);
    @(negedge clk);
    check("t2_wr", 32'(Tx_wr), 32'd1);
    check("t2_data", 32'(Tx_data), 32'hA5);
    wait_idle(60);
    check("t2_done", 32'(arb_busy), 32'd0);

    // Reset in the middle of WAIT_DONE (ptr is 1 after serving 0)
    req_data = 32'h13121110;
    push(2'd1, 8'h11);
    pend[1] = 1;
    wait_wr(30);
    wait_busy(1'b1, 20);
    repeat (2) @(negedge clk);
    check("t1_in_frame", 32'(arb_busy), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk);
    #1 reset = 1'b1;
    wait_busy(1'b0, 30);

    // All four held, pointer back at 0 after reset
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    pend = '{2, 1, 1, 1};
    wait_idle(300);

    // Serve 1 so ptr=2, then 0 and 1 wrap while 3 drops before being granted
    push(2'd1, 8'h11);
    pend[1] = 1;
    wait_idle(60);
    @(posedge clk);
    #1 arb_en = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_en_off", 32'(Tx_en), 32'd0);
    pend[0] = 1;
    pend[1] = 1;
    pend[3] = 1;
    repeat (3) @(negedge clk);
    check("t4_no_grant", 32'(arb_busy), 32'd0);
    pend[3] = 0;
    repeat (2) @(negedge clk);
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    arb_en = 1'b1;
    wait_idle(100);

    // arb_en dropped during WAIT_DONE: frame completes, no new grants until re-enabled
    push(2'd2, 8'h12);
    pend[2] = 1;
    wait_wr(30);
    wait_busy(1'b1, 20);
    repeat (2) @(negedge clk);
    arb_en = 1'b0;
    @(negedge clk);
    check("t5_en_follow", 32'(Tx_en), 32'd0);
    check("t5_frame_on", 32'(arb_busy), 32'd1);
    pend = '{1, 1, 1, 1};
    repeat (30) @(negedge clk);
    check("t5_held_off", 32'(arb_busy), 32'd0);
    check("t5_req_pending", 32'(req), 32'hF);
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    push(2'd1, 8'h11);
    push(2'd2, 8'h12);
    arb_en = 1'b1;
    wait_idle(200);

    // Transmitter never goes busy
    model_en = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    push(2'd3, 8'h13);
    push(2'd0, 8'h10);
    pend[3] = 1;
    pend[0] = 1;
    wait_wr(30);
    repeat (63) @(negedge clk);
    check("t6_err_early", 32'(tx_err), 32'd0);
    check("t6_busy_early", 32'(arb_busy), 32'd1);
    @(negedge clk);
    check("t6_err_set", 32'(tx_err), 32'd1);
    check("t6_idle", 32'(arb_busy), 32'd0);
    wait_wr(10);
    repeat (80) @(negedge clk);
    check("t6_err_sticky", 32'(tx_err), 32'd1);
    check("t6_idle2", 32'(arb_busy), 32'd0);
`else
    push(2'd3, 8'h13);
    pend[3] = 1;
    wait_wr(30);
    repeat (70) @(negedge clk);
    check("t6_stuck", 32'(arb_busy), 32'd1);
    check("t6_no_err", 32'(tx_err), 32'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_rst_idle", 32'(arb_busy), 32'd0);
    check("t6_rst_err", 32'(tx_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
